// File: rtl/dm_responder.sv
// Data-memory responder behind the M-stage load/store port.
// Fixed-latency word memory with error checks and a store log.
module dm_responder #(
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LATENCY    = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        log_valid,
  output logic [31:0] log_pc,
  output logic [31:0] log_addr,
  output logic [31:0] log_data
);

  localparam int WORDS = 1 << DEPTH_LOG2;

  if (LATENCY < 1 || LATENCY > 7) begin : g_bad_latency
    $error("dm_responder: LATENCY must be in 1..7");
  end

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
  } req_t;

  state_t      state;
  state_t      state_n;
  logic [2:0]  cnt;
  logic [2:0]  cnt_n;
  logic        accept;
  logic        enter_resp;
  req_t        live;
  req_t        held;
  req_t        cur;
  logic [31:0] mem [WORDS];
  logic [31:0] off;
  logic [DEPTH_LOG2-1:0] idx;
  logic        err;
  logic        commit;
  logic [31:0] old_word;
  logic [31:0] merged;

  assign live = {req_we, req_addr, req_wdata, req_be, req_pc};

  // With single-edge latency the request takes effect on its own
  // acceptance edge, so the live inputs are used instead of the latch.
  assign cur = (LATENCY == 1) ? live : held;

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state, ready and acceptance decode.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    req_ready = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: req_ready = reset;
      BUSY: begin
        if (cnt == 3'd0) state_n = RESP;
        else             cnt_n   = cnt - 3'd1;
      end
      RESP: begin
        req_ready = reset;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
    accept = req_valid & req_ready;
    if (accept) begin
      if (LATENCY == 1) begin
        state_n = RESP;
      end else begin
        state_n = BUSY;
        cnt_n   = 3'(LATENCY - 2);
      end
    end
  end

  assign enter_resp = reset && (state_n == RESP);

  // Latch the accepted request for the busy period.
  always_ff @(posedge clk) begin
    if (!reset)      held <= '0;
    else if (accept) held <= live;
  end

  assign off = cur.addr - BASE_ADDR;
  assign idx = off[DEPTH_LOG2+1:2];
  assign err = (off[1:0] != 2'b00)
             | (cur.addr < BASE_ADDR)
             | (off[31:2] >= 30'(WORDS));
  assign old_word = mem[idx];
  assign commit = enter_resp & cur.we & ~err & (|cur.be);

  // Byte-enable merge of store data into the current word.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (cur.be[i]) merged[8*i +: 8] = cur.wdata[8*i +: 8];
    end
  end

  // Word storage; cleared on reset, written at the commit edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= 32'd0;
    end else if (commit) begin
      mem[idx] <= merged;
    end
  end

  // Response and log registers; data fields hold between pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rsp_err   <= 1'b0;
      rsp_rdata <= 32'd0;
      log_valid <= 1'b0;
      log_pc    <= 32'd0;
      log_addr  <= 32'd0;
      log_data  <= 32'd0;
    end else begin
      log_valid <= commit;
      if (enter_resp) begin
        rsp_err   <= err;
        rsp_rdata <= (err | cur.we) ? 32'd0 : old_word;
      end
      if (commit) begin
        log_pc   <= cur.pc;
        log_addr <= {cur.addr[31:2], 2'b00};
        log_data <= merged;
      end
    end
  end

  assign rsp_valid = (state == RESP);

endmodule
